// File: rtl/fcl_pro_stream.sv
// fcl_pro_stream: binary fully-connected first layer, streaming form.
// Each accepted beat carries one signed pixel and PARALLEL weight bits. Each
// lane adds +pixel for weight 1 and -pixel for weight 0 over IN_LEN beats.
// The lane sums are then arithmetic-shifted, saturated, and presented on a
// valid/ready output.
// Optional build macro FCL_PRO_STREAM_SIGN_EN adds out_sign, the per-lane sign
// of the pre-shift sum, which is the binarised activation for the next layer.
module fcl_pro_stream #(
   parameter int PIX_WIDTH = 8,
   parameter int PARALLEL  = 16,
   parameter int IN_LEN    = 784,
   parameter int ACC_WIDTH = 20,
   parameter int OUT_WIDTH = 8,
   localparam int SHIFT_W  = $clog2(ACC_WIDTH),
   localparam int CNT_W    = $clog2(IN_LEN + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [PIX_WIDTH-1:0]   in_pixel,
   input  logic [PARALLEL-1:0]           in_w,
   input  logic [SHIFT_W-1:0]            shift,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PARALLEL*OUT_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]              beat_cnt
`ifdef FCL_PRO_STREAM_SIGN_EN
   ,
   output logic [PARALLEL-1:0]           out_sign
`endif
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_LEN - 1);

   // Saturation bounds held at accumulator width so they compare directly
   // against the shifted sum.
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {S_ACC, S_OUT} state_t;

   state_t                        state;
   state_t                        state_nxt;
   logic                          beat_acc;
   logic                          last_beat;
   logic signed [ACC_WIDTH-1:0]   pix_ext;
   logic signed [ACC_WIDTH-1:0]   acc  [PARALLEL];
   logic signed [ACC_WIDTH-1:0]   term [PARALLEL];
   logic signed [ACC_WIDTH-1:0]   full [PARALLEL];
   logic [PARALLEL*OUT_WIDTH-1:0] res_data;
`ifdef FCL_PRO_STREAM_SIGN_EN
   logic [PARALLEL-1:0]           res_sign;
`endif

   // Arithmetic right shift; amounts at or beyond the width give 0 or -1.
   function automatic logic signed [ACC_WIDTH-1:0] ashr(
      input logic signed [ACC_WIDTH-1:0] v,
      input logic [SHIFT_W-1:0]          s
   );
      return v >>> s;
   endfunction

   // Clamp a wide signed value into the signed output lane range.
   function automatic logic signed [OUT_WIDTH-1:0] sat(
      input logic signed [ACC_WIDTH-1:0] v
   );
      if (v > SAT_MAX) begin
         return SAT_MAX[OUT_WIDTH-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[OUT_WIDTH-1:0];
      end else begin
         return v[OUT_WIDTH-1:0];
      end
   endfunction

   // Widen the pixel before negation so that negating the most negative pixel
   // still fits.
   assign pix_ext   = {{(ACC_WIDTH - PIX_WIDTH){in_pixel[PIX_WIDTH-1]}}, in_pixel};
   assign beat_acc  = in_valid && in_ready;
   assign last_beat = beat_acc && (beat_cnt == LAST_CNT);

   for (genvar g = 0; g < PARALLEL; g++) begin : g_lane
      assign term[g] = in_w[g] ? pix_ext : -pix_ext;
      assign full[g] = acc[g] + term[g];
      assign res_data[g*OUT_WIDTH +: OUT_WIDTH] = sat(ashr(full[g], shift));
`ifdef FCL_PRO_STREAM_SIGN_EN
      assign res_sign[g] = ~full[g][ACC_WIDTH-1];
`endif
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; clear overrides every other transition.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_ACC: begin
            in_ready = 1'b1;
            if (in_valid && (beat_cnt == LAST_CNT)) begin
               state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = S_ACC;
            end
         end
         default: state_nxt = S_ACC;
      endcase
      if (clear) begin
         state_nxt = S_ACC;
      end
   end

   // Accumulate per lane; on the final beat register the result and restart.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         out_data <= '0;
         for (int i = 0; i < PARALLEL; i++) begin
            acc[i] <= '0;
         end
      end else if (clear) begin
         beat_cnt <= '0;
         for (int i = 0; i < PARALLEL; i++) begin
            acc[i] <= '0;
         end
      end else if (last_beat) begin
         beat_cnt <= '0;
         out_data <= res_data;
         for (int i = 0; i < PARALLEL; i++) begin
            acc[i] <= '0;
         end
      end else if (beat_acc) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
         for (int i = 0; i < PARALLEL; i++) begin
            acc[i] <= full[i];
         end
      end
   end

`ifdef FCL_PRO_STREAM_SIGN_EN
   // Sign of the pre-shift sum, captured alongside out_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sign <= '0;
      end else if (!clear && last_beat) begin
         out_sign <= res_sign;
      end
   end
`endif

endmodule
